// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into little-endian 32-bit words and writes
// each word to the four byte-wide instruction memory banks at consecutive word
// addresses, holding the CPU while a load is in progress.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to consume one trailing
// checksum byte (8-bit sum of the payload) after the payload and flag a
// mismatch on err. Without it, err is tied to 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse that begins a load (sampled only in IDLE)
//   load_len        words to load, clamped to DEPTH, captured on start
//   in_valid/in_data/in_ready  byte-stream handshake
//   bank_we         per-bank write strobe (bit i -> bank i)
//   wa, wd          shared word address / write data (bank i gets wd[8i+7:8i])
//   cpu_hold, busy  high while the loader is not idle
//   done            one-cycle pulse when a load completes
//   err             sticky checksum mismatch, cleared on the next start
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [3:0]        bank_we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic [1:0]        idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic [3:0]        bank_we_q, bank_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_c;
  logic              last_word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign accept_c    = in_valid && in_ready_q;
  // The word being written is the last one when its address+1 reaches the count.
  assign last_word_c = ((CNT_W'(wa_q) + CNT_W'(1)) == cnt_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    idx_d   = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = (load_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : load_len;
          wa_d  = '0;
          idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = '0;
          err_d = 1'b0;
`endif
          state_d = (cnt_d == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept_c) begin
          wd_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // Address is held on the final word so it never reaches DEPTH.
        if (last_word_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          wa_d    = wa_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_c) begin
          if (in_data != sum_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == RECV) || (state_d == CHK);
`else
    in_ready_d = (state_d == RECV);
`endif
    bank_we_d = (state_d == WRITE) ? 4'hF : 4'h0;
    busy_d    = (state_d != IDLE);
    // done lands in the cycle after DONE, together with busy falling.
    done_d    = (state_q == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      bank_we_q  <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      bank_we_q  <= bank_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready = in_ready_q;
  assign bank_we  = bank_we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a transaction-level model (word count,
// byte packing, running sum) predicts every output each cycle.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int LIM    = 20000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic [3:0]        bank_we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bank_we(bank_we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // model: current-cycle predictions plus load bookkeeping
  bit         m_busy, m_ready, m_we, m_done, m_tail, m_err;
  int         m_wa;
  logic [31:0] m_wd;
  int         m_words, m_written, m_nb;
  logic [31:0] m_word;
  logic [7:0] m_sum;

  byte unsigned src[$];
  int    log_wa[$];
  logic [31:0] log_wd[$];
  int    done_cnt, done_cyc, acc_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_we = 0; m_done = 0; m_tail = 0; m_err = 0;
    m_wa = 0; m_wd = '0; m_words = 0; m_written = 0; m_nb = 0; m_word = '0; m_sum = '0;
  endtask

  // One clock: predict next outputs from the present inputs, clock, compare.
  task automatic cycle();
    bit acc, n_busy, n_ready, n_we, n_done, n_tail, n_err;
    int n_wa;
    logic [31:0] n_wd;
    acc = in_valid && m_ready;
    n_busy = m_busy; n_ready = 0; n_we = 0; n_done = 0; n_tail = 0; n_err = m_err;
    n_wa = m_wa; n_wd = m_wd;
    if (!m_busy) begin
      if (start) begin
        m_words = (int'(load_len) > DEPTH) ? DEPTH : int'(load_len);
        m_written = 0; m_nb = 0; m_sum = '0; n_err = 0; n_busy = 1;
        if (m_words == 0) n_tail = 1; else n_ready = 1;
      end
    end else if (m_tail) begin
      n_busy = 0; n_done = 1;
    end else if (m_we) begin
      m_written++;
      if (m_written == m_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_ready = 1;
`else
        n_tail = 1;
`endif
      end else n_ready = 1;
    end else if (acc) begin
      if (m_written == m_words) begin
        if (in_data != m_sum) n_err = 1;
        n_tail = 1;
      end else begin
        m_word[8*m_nb +: 8] = in_data;
        m_sum = m_sum + in_data;
        m_nb++;
        if (m_nb == 4) begin
          m_nb = 0; n_we = 1; n_wa = m_written; n_wd = m_word;
        end else n_ready = 1;
      end
    end else n_ready = 1;

    if (acc) begin
      acc_total++;
      if (src.size() > 0) void'(src.pop_front());
    end

    @(posedge clk);
    #1;
    cyc++;
    m_busy = n_busy; m_ready = n_ready; m_we = n_we; m_done = n_done;
    m_tail = n_tail; m_err = n_err; m_wa = n_wa; m_wd = n_wd;

    chk("in_ready", in_ready, m_ready);
    chk("bank_we", bank_we, m_we ? 4'hF : 4'h0);
    chk("busy", busy, m_busy);
    chk("cpu_hold", cpu_hold, m_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    if (m_we) begin
      chk("wa", wa, m_wa);
      chk("wd", wd, m_wd);
    end
    if (bank_we != 4'h0) begin
      log_wa.push_back(int'(wa));
      log_wd.push_back(wd);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bank_we", bank_we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    log_wa.delete(); log_wd.delete(); done_cnt = 0; done_cyc = -1;
  endtask

  // Random payload for `words` words plus (when enabled) a checksum byte.
  task automatic fill_random(input int words, input bit bad_chk);
    byte unsigned b, s;
    src.delete(); s = 0;
    for (int i = 0; i < 4 * words; i++) begin
      b = 8'($urandom);
      src.push_back(b);
      s = s + b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (words > 0) src.push_back(bad_chk ? s + 8'd1 : s);
`else
    if (bad_chk) s = 0;
`endif
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid + stray starts
  task automatic run_load(input int len, input int mode, input int abort_after, output int start_cyc);
    int n;
    acc_total = 0;
    load_len = (ADDR_W + 1)'(len);
    start = 1'b1; in_valid = 1'b0;
    start_cyc = cyc;
    cycle();
    start = 1'b0;
    n = 0;
    while (!m_done && n < LIM) begin
      in_data = (src.size() > 0) ? src[0] : 8'($urandom);
      case (mode)
        0: in_valid = (src.size() > 0);
        1: in_valid = (src.size() > 0) && cyc[0];
        default: in_valid = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2 && m_busy && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
        load_len = (ADDR_W + 1)'($urandom_range(0, 20));
      end else start = 1'b0;
      cycle();
      n++;
      if (abort_after >= 0 && acc_total == abort_after) begin
        do_reset();
        return;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    if (n >= LIM) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout len=%0d: no done after %0d cycles", len, n);
    end
  endtask

  task automatic dir_bytes();
    byte unsigned d[8];
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    src.delete();
    foreach (d[i]) src.push_back(d[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    src.push_back(8'hB6);
`endif
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"}, log_wa.size(), 2);
    if (log_wa.size() == 2) begin
      chk({tag, "_wa0"}, log_wa[0], 0);
      chk({tag, "_wd0"}, log_wd[0], 32'h0000_0013);
      chk({tag, "_wa1"}, log_wa[1], 1);
      chk({tag, "_wd1"}, log_wd[1], 32'h0010_0093);
    end
    chk({tag, "_done"}, done_cnt, 1);
  endtask

  task automatic idle(input int k);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    int sc, zeros;
    model_reset();
    do_reset();
    idle(2);

    // two-word directed load, continuous and gapped valid
    clear_logs(); dir_bytes(); run_load(2, 0, -1, sc); idle(2);
    check_two_words("cont");
    clear_logs(); dir_bytes(); run_load(2, 1, -1, sc); idle(2);
    check_two_words("gap");

    // zero-length load: no writes, done two cycles after start
    clear_logs(); src.delete(); run_load(0, 0, -1, sc); idle(2);
    chk("len0_nwr", log_wa.size(), 0);
    chk("len0_done_lat", done_cyc - sc, 2);

    // oversize load clamps to DEPTH words
    clear_logs(); fill_random(DEPTH, 0); run_load(1100, 2, -1, sc); idle(2);
    chk("clamp_nwr", log_wa.size(), DEPTH);
    zeros = 0;
    foreach (log_wa[i]) if (log_wa[i] == 0) zeros++;
    chk("clamp_zero_wa", zeros, 1);
    if (log_wa.size() > 0) chk("clamp_last_wa", log_wa[log_wa.size() - 1], DEPTH - 1);

    // reset after six bytes: only the first word lands, then reload from 0
    clear_logs(); dir_bytes(); run_load(2, 0, 6, sc);
    chk("abort_nwr", log_wa.size(), 1);
    if (log_wa.size() > 0) chk("abort_wa0", log_wa[0], 0);
    idle(2);
    clear_logs(); fill_random(1, 0); run_load(1, 0, -1, sc); idle(1);
    chk("reload_nwr", log_wa.size(), 1);
    if (log_wa.size() > 0) chk("reload_wa0", log_wa[0], 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    clear_logs();
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_load(1, 0, -1, sc); idle(2);
    chk("chk_good_err", err, 0);
    if (log_wd.size() > 0) chk("chk_wd", log_wd[0], 32'h0403_0201);
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_load(1, 0, -1, sc); idle(5);
    chk("chk_bad_err", err, 1);
    src.delete(); run_load(0, 0, -1, sc); idle(1);
    chk("chk_err_cleared", err, 0);
`endif

    // randomized loads
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(0, 9);
      clear_logs();
      fill_random(len, $urandom_range(0, 2) == 0);
      run_load(len, $urandom_range(0, 2), -1, sc);
      idle($urandom_range(0, 3));
      chk("rand_nwr", log_wa.size(), len);
      chk("rand_done", done_cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
